decode_stage: RTL

- Consumer end of the instruction-fetch interface.
- Latches the fetched instruction word and PC+1 into an IF/ID register.
- Decodes fields, reads a 32x32 register file and resolves BEQ/BNE/J in decode.
- Returns redirect (dec, pc_mux) and stall (enbl) to fetch, and drives a registered ID/EX bundle to execute.

---
 rtl/decode_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: IF/ID latch, field decode, 32x32 register file and BEQ/BNE/J resolution in decode.
// Ports: clk/rst (sync, active-high); fetch side instr_in, pc_plus1_in, bubble_in in and dec,
// pc_mux, enbl out; writeback wb_we/wb_addr/wb_data; load-use inputs ex_mem_read/ex_rt;
// registered ID/EX bundle id_valid, id_opcode, id_funct, id_rs/rt/rd, id_rs_data/rt_data,
// id_imm, id_pc_plus1.
module decode_stage #(
  parameter int PC_W  = 7,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_plus1_in,
  input  logic            bubble_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rt,
  output logic            dec,
  output logic [PC_W-1:0] pc_mux,
  output logic            enbl,
  output logic            id_valid,
  output logic [5:0]      id_opcode,
  output logic [5:0]      id_funct,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [31:0]     id_rs_data,
  output logic [31:0]     id_rt_data,
  output logic [31:0]     id_imm,
  output logic [PC_W-1:0] id_pc_plus1
);
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  typedef struct packed {
    logic            valid;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
  } idex_t;
  logic            ifid_valid_q;
  logic [31:0]     ifid_instr_q;
  logic [PC_W-1:0] ifid_pc_q;
  logic [31:0]     rf_q [NREGS];
  idex_t           id_d, id_q;
  logic [5:0]      op;
  logic [4:0]      rs, rt;
  logic [31:0]     rs_data, rt_data;
  logic            rs_used, rt_used, stall, taken;

  assign op = ifid_instr_q[31:26];
  assign rs = ifid_instr_q[25:21];
  assign rt = ifid_instr_q[20:16];
  // write-through bypass so a same-cycle writeback is visible to the branch compare
  assign rs_data = (rs == '0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
  assign rt_data = (rt == '0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];
  assign rs_used = op != OP_J;
  assign rt_used = op == OP_R || op == OP_BEQ || op == OP_BNE || op == OP_SW;
  assign stall = ~rst & ifid_valid_q & ex_mem_read & (ex_rt != '0) &
                 ((rs_used & (ex_rt == rs)) | (rt_used & (ex_rt == rt)));
  assign taken = op == OP_J || (op == OP_BEQ && rs_data == rt_data) ||
                 (op == OP_BNE && rs_data != rt_data);
  assign dec = ~rst & ifid_valid_q & ~stall & taken;
  assign pc_mux = rst ? '0 : !dec ? ifid_pc_q : (op == OP_J) ? ifid_instr_q[PC_W-1:0] :
                  ifid_pc_q + ifid_instr_q[PC_W-1:0];
  assign enbl = ~stall;

  always_comb begin
    id_d = '0;
    if (ifid_valid_q && !stall)
      id_d = '{valid: 1'b1, opcode: op, funct: ifid_instr_q[5:0], rs: rs, rt: rt,
               rd: ifid_instr_q[15:11], rs_data: rs_data, rt_data: rt_data,
               imm: {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]}, pc: ifid_pc_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      id_q         <= '0;
    end else begin
      id_q <= id_d;
      if (dec)
        ifid_valid_q <= 1'b0;
      else if (!stall) begin
        ifid_valid_q <= ~bubble_in;
        ifid_instr_q <= instr_in;
        ifid_pc_q    <= pc_plus1_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    else if (wb_we && wb_addr != '0)
      rf_q[wb_addr] <= wb_data;
  end

  assign id_valid    = id_q.valid;
  assign id_opcode   = id_q.opcode;
  assign id_funct    = id_q.funct;
  assign id_rs       = id_q.rs;
  assign id_rt       = id_q.rt;
  assign id_rd       = id_q.rd;
  assign id_rs_data  = id_q.rs_data;
  assign id_rt_data  = id_q.rt_data;
  assign id_imm      = id_q.imm;
  assign id_pc_plus1 = id_q.pc;
endmodule
